// File: rtl/wbm_pkg.sv
// wbm_pkg: shared state encoding, bus constants and slave region map for the Wishbone initiator.
package wbm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        BUS,
        RESP
    } wbm_state_e;

    localparam logic [3:0]  WBM_SEL_ALL    = 4'hF;
    localparam logic [31:0] WBM_STRIDE     = 32'd4;

    localparam logic [31:0] WBM_CTRL_BASE  = 32'h3000_0000;
    localparam logic [31:0] WBM_QUERY_BASE = 32'h3001_0000;
    localparam logic [31:0] WBM_LEAF_BASE  = 32'h3002_0000;
    localparam logic [31:0] WBM_BEST_BASE  = 32'h3003_0000;
    localparam logic [31:0] WBM_NODE_BASE  = 32'h3004_0000;
    localparam logic [31:0] WBM_ADDR_MASK  = 32'hFFFF_0000;

    function automatic logic [31:0] wbm_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wbm_timeout_cnt.sv
// wbm_timeout_cnt: counts BUS cycles without ack and flags the cycle in which the limit is reached.
module wbm_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic ack_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Idle between beats (WDATA/RESP/IDLE) always lasts a cycle, so clearing while not running resets it on BUS entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (!run_i)
            cnt_q <= '0;
        else if (!ack_i)
            cnt_q <= cnt_q + CW'(1);
    end

    assign expired_o = run_i && !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wbm_initiator.sv
// wbm_initiator: Wishbone classic single-beat master driven by a command port with write/read data streams.
// Define WBM_TIMEOUT_EN to abort a beat after TIMEOUT_CYCLES cycles without ack and flag err.
module wbm_initiator
    import wbm_pkg::*;
#(
    parameter int LEN_W          = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);
    wbm_state_e       state_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [LEN_W-1:0] rem_q;
    logic             cmd_ready_q, wdata_ready_q, rsp_valid_q, busy_q, done_q, err_q;
    logic             cyc_q, stb_q, bus_we_q;
    logic [3:0]       sel_q;
    logic [31:0]      adr_q, dat_q, rsp_data_q;
    logic [31:0]      next_addr;
    logic             expired;

    assign next_addr = addr_q + WBM_STRIDE;

`ifdef WBM_TIMEOUT_EN
    wbm_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .run_i    (stb_q),
        .ack_i    (wbm_ack_i),
        .expired_o(expired)
    );
    assign err = err_q;
`else
    logic unused_timeout;
    assign expired        = 1'b0;
    assign unused_timeout = err_q | (TIMEOUT_CYCLES == 0);
    assign err            = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            rem_q         <= '0;
            cmd_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            bus_we_q      <= 1'b0;
            sel_q         <= '0;
            adr_q         <= '0;
            dat_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q      <= wbm_align(cmd_addr);
                    we_q        <= cmd_we;
                    rem_q       <= cmd_len;
                    err_q       <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                    if (cmd_we) begin
                        state_q       <= WDATA;
                        wdata_ready_q <= 1'b1;
                    end else begin
                        state_q  <= BUS;
                        cyc_q    <= 1'b1;
                        stb_q    <= 1'b1;
                        sel_q    <= WBM_SEL_ALL;
                        bus_we_q <= 1'b0;
                        adr_q    <= wbm_align(cmd_addr);
                    end
                end
                WDATA: if (wdata_valid) begin
                    dat_q         <= wdata;
                    wdata_ready_q <= 1'b0;
                    state_q       <= BUS;
                    cyc_q         <= 1'b1;
                    stb_q         <= 1'b1;
                    sel_q         <= WBM_SEL_ALL;
                    bus_we_q      <= 1'b1;
                    adr_q         <= addr_q;
                end
                BUS: if (wbm_ack_i || expired) begin
                    cyc_q    <= 1'b0;
                    stb_q    <= 1'b0;
                    sel_q    <= '0;
                    bus_we_q <= 1'b0;
                    if (!wbm_ack_i) begin
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (!we_q) begin
                        rsp_data_q  <= wbm_dat_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (rem_q == '0) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        addr_q        <= next_addr;
                        rem_q         <= rem_q - LEN_W'(1);
                        wdata_ready_q <= 1'b1;
                        state_q       <= WDATA;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    if (rem_q == '0) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        addr_q   <= next_addr;
                        rem_q    <= rem_q - LEN_W'(1);
                        state_q  <= BUS;
                        cyc_q    <= 1'b1;
                        stb_q    <= 1'b1;
                        sel_q    <= WBM_SEL_ALL;
                        bus_we_q <= 1'b0;
                        adr_q    <= next_addr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = bus_we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wbm_initiator.sv
// tb_wbm_initiator: randomized command traffic against a behavioural slave and a transaction-level model.
module tb_wbm_initiator;
    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wdata_valid = 1'b0, wdata_ready;
    logic [31:0]      wdata = '0;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic             busy, done, err;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o;
    logic             wbm_ack_i = 1'b0;
    logic [31:0]      wbm_dat_i = '0;

    wbm_initiator #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .done(done), .err(err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    int          total = 0;
    int          bad = 0;
    beat_t       exp_q[$];
    logic [31:0] fixed_wd[$];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int          lat = 0;
    bit          hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Slave: random ack latency, one ack per strobe, memory backed by init_word for unwritten words.
    always @(negedge clk) begin
        if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
            check("stb_after_ack", 32'({wbm_cyc_o, wbm_stb_o, wbm_sel_o}), 32'd0);
        end else if (wbm_stb_o && !hold && !rst) begin
            if (lat > 0) lat--;
            else begin
                beat_t e;
                wbm_ack_i = 1'b1;
                lat = $urandom_range(0, 3);
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("adr", wbm_adr_o, e.adr);
                    check("we", 32'(wbm_we_o), 32'(e.we));
                    check("sel", 32'(wbm_sel_o), 32'hF);
                    check("cyc", 32'(wbm_cyc_o), 32'd1);
                    if (e.we) check("dat_o", wbm_dat_o, e.dat);
                end
                if (wbm_we_o) slave_mem[wbm_adr_o] = wbm_dat_o;
                else wbm_dat_i = slave_mem.exists(wbm_adr_o) ? slave_mem[wbm_adr_o] : init_word(wbm_adr_o);
            end
        end
    end

    task automatic do_reset();
        #1 rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_cmd(input bit we, input logic [31:0] a, input int len, input int bp);
        logic [31:0] base, adr, d, held;
        logic [31:0] wd[$];
        logic [31:0] rd[$];
        int n;
        base = {a[31:2], 2'b00};
        for (int i = 0; i <= len; i++) begin
            adr = base + 32'(4 * i);
            if (we) begin
                d = (fixed_wd.size() > 0) ? fixed_wd.pop_front() : $urandom;
                wd.push_back(d);
                ref_mem[adr] = d;
                exp_q.push_back('{adr, 1'b1, d});
            end else begin
                rd.push_back(ref_mem.exists(adr) ? ref_mem[adr] : init_word(adr));
                exp_q.push_back('{adr, 1'b0, 32'd0});
            end
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_addr = a;
        cmd_len = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
        cmd_addr = $urandom;
        check("busy", 32'(busy), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("err_cleared", 32'(err), 32'd0);
        if (we) check("wdata_ready_n1", 32'(wdata_ready), 32'd1);
        else check("stb_n1", 32'(wbm_stb_o), 32'd1);
        for (int i = 0; i <= len; i++) begin
            n = 0;
            if (we) begin
                while (!wdata_ready && n < 200) begin tick(); n++; end
                check("wdata_ready_wait", 32'(wdata_ready), 32'd1);
                if (!wdata_ready) begin do_reset(); return; end
                check("no_stb_in_wdata", 32'(wbm_stb_o), 32'd0);
                repeat ($urandom_range(0, 2)) tick();
                wdata = wd[i];
                wdata_valid = 1'b1;
                tick();
                wdata_valid = 1'b0;
                wdata = $urandom;
                check("stb_after_wdata", 32'(wbm_stb_o), 32'd1);
                check("dat_hold", wbm_dat_o, wd[i]);
            end else begin
                while (!rsp_valid && n < 200) begin tick(); n++; end
                check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
                if (!rsp_valid) begin do_reset(); return; end
                held = rsp_data;
                repeat (bp) begin
                    tick();
                    check("rsp_stable", rsp_data, held);
                    check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                    check("no_stb_in_resp", 32'(wbm_stb_o), 32'd0);
                end
                check("rsp_data", rsp_data, rd[i]);
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
            end
        end
        n = 0;
        if (we) while (!done && n < 200) begin tick(); n++; end
        check("done", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
        check("err_at_done", 32'(err), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("beats_consumed", 32'(exp_q.size()), 32'd0);
        if (exp_q.size() > 0) exp_q.delete();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bus", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_dat", wbm_dat_o, 32'd0);
        check("rst_streams", 32'({wdata_ready, rsp_valid}), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        tick();

        fixed_wd.push_back(32'h1);
        do_cmd(1'b1, 32'h3000_0004, 0, 0);
        check("debug_reg", slave_mem[32'h3000_0004], 32'h1);

        fixed_wd.push_back(32'h1234_5678);
        fixed_wd.push_back(32'h0055_AAAA);
        do_cmd(1'b1, 32'h3001_0000, 1, 0);
        check("query_lo", slave_mem[32'h3001_0000], 32'h1234_5678);
        check("query_hi", slave_mem[32'h3001_0004], 32'h0055_AAAA);
        do_cmd(1'b0, 32'h3001_0000, 1, 2);

        do_cmd(1'b0, 32'h3003_0008, 1, 5);
        do_cmd(1'b0, 32'hFFFF_FFFC, 1, 1);
        do_cmd(1'b1, 32'h3002_0003, 2, 0);

        for (int k = 0; k < 40; k++)
            do_cmd(1'($urandom_range(0, 1)),
                   32'h3000_0000 + (32'($urandom_range(0, 4)) << 16) + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3)),
                   $urandom_range(0, 6), $urandom_range(0, 3));

        hold = 1'b1;
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_addr = 32'h3000_0000;
        cmd_len = LEN_W'(3);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (wbm_stb_o && n < 120) begin n++; tick(); end
`ifdef WBM_TIMEOUT_EN
        check("timeout_cycles", 32'(n), 32'd8);
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_cyc", 32'(wbm_cyc_o), 32'd0);
        tick();
        check("timeout_done_pulse", 32'(done), 32'd0);
        check("timeout_err_sticky", 32'(err), 32'd1);
        check("timeout_idle", 32'(cmd_ready), 32'd1);
`else
        check("no_timeout_stb", 32'(n), 32'd120);
        check("no_timeout_err", 32'(err), 32'd0);
        check("no_timeout_done", 32'(done), 32'd0);
        do_reset();
`endif
        hold = 1'b0;
        do_cmd(1'b0, 32'h3004_0000, 0, 0);

        hold = 1'b1;
        cmd_valid = 1'b1;
        cmd_we = 1'b1;
        cmd_addr = 32'h3004_0010;
        cmd_len = LEN_W'(2);
        tick();
        cmd_valid = 1'b0;
        wdata_valid = 1'b1;
        wdata = 32'hCAFE_F00D;
        tick();
        wdata_valid = 1'b0;
        check("rst_test_stb", 32'(wbm_stb_o), 32'd1);
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("rst_async_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        check("rst_async_done", 32'(done), 32'd0);
        tick();
        check("rst_hold_done", 32'(done), 32'd0);
        rst = 1'b0;
        hold = 1'b0;
        tick();
        check("rst_release_ready", 32'(cmd_ready), 32'd1);
        check("rst_release_busy", 32'(busy), 32'd0);
        check("rst_release_done", 32'(done), 32'd0);
        do_cmd(1'b0, 32'h3004_0010, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
